// File: rtl/lcd_pkg.sv
// Shared definitions for the serial LCD receive model: command codes, decoder states, pixel format.
// No logic: constants and types only.
// No flow control.
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        DEC_IDLE,
        DEC_CASET,
        DEC_RASET,
        DEC_RAMWR_HI,
        DEC_RAMWR_LO
    } dec_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/lcd_sync_bit.sv
// Multi-flop synchronizer for one asynchronous pin, with a selectable reset level.
// Latency SYNC_STAGES clk cycles.
// No flow control.
module lcd_sync_bit #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/lcd_spi_rx.sv
// Serial LCD receiver: oversampled 4-wire pins to tagged bytes; with LCD_SPI_RX_PIXEL_DECODE_EN, CASET/RASET/RAMWR to pixels.
// Latency: byte_valid SYNC_STAGES+1 clk after the 8th scl rise; pix_valid coincides with the completing byte_valid.
// No backpressure: the serial master is free-running, outputs are pulses.
module lcd_spi_rx
    import lcd_pkg::*;
#(
    parameter int WIDTH       = 128,
    parameter int HEIGHT      = 160,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        scl,
    input  logic        sda,
    input  logic        rs,
    input  logic        lcd_rst,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_is_data,
    output logic        frame_err,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y
);

    logic cs_s, scl_s, sda_s, rs_s, lcd_rst_s;

    lcd_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset_n(reset_n), .d(cs), .q(cs_s));
    lcd_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_scl (
        .clk(clk), .reset_n(reset_n), .d(scl), .q(scl_s));
    lcd_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sda (
        .clk(clk), .reset_n(reset_n), .d(sda), .q(sda_s));
    lcd_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_rs (
        .clk(clk), .reset_n(reset_n), .d(rs), .q(rs_s));
    lcd_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_rst (
        .clk(clk), .reset_n(reset_n), .d(lcd_rst), .q(lcd_rst_s));

    logic       scl_d, cs_d;
    logic       clr, scl_rise, cs_rise, byte_done;
    logic [2:0] bit_cnt;
    logic [6:0] shift_q;
    logic [7:0] new_byte;

    assign clr       = ~lcd_rst_s;
    assign scl_rise  = scl_s & ~scl_d & ~cs_s;
    assign cs_rise   = cs_s & ~cs_d;
    assign byte_done = scl_rise && (bit_cnt == 3'd7);
    assign new_byte  = {shift_q, sda_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_d        <= 1'b1;
            cs_d         <= 1'b1;
            bit_cnt      <= '0;
            shift_q      <= '0;
            byte_valid   <= 1'b0;
            byte_data    <= '0;
            byte_is_data <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            scl_d      <= scl_s;
            cs_d       <= cs_s;
            byte_valid <= 1'b0;
            if (clr) begin
                bit_cnt      <= '0;
                shift_q      <= '0;
                byte_data    <= '0;
                byte_is_data <= 1'b0;
                frame_err    <= 1'b0;
            end else if (scl_rise) begin
                shift_q <= new_byte[6:0];
                if (bit_cnt == 3'd7) begin
                    bit_cnt      <= '0;
                    byte_valid   <= 1'b1;
                    byte_data    <= new_byte;
                    byte_is_data <= rs_s;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else if (cs_rise && bit_cnt != 3'd0) begin
                // partial byte is dropped; the error stays until a reset
                bit_cnt   <= '0;
                frame_err <= 1'b1;
            end
        end
    end

`ifdef LCD_SPI_RX_PIXEL_DECODE_EN
    localparam logic [7:0] XE_RST = 8'(WIDTH - 1);
    localparam logic [7:0] YE_RST = 8'(HEIGHT - 1);

    dec_state_t state_q, state_d;
    logic [1:0] pcnt_q, pcnt_d;
    logic [7:0] pstart_q, pstart_d;
    logic [7:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [7:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [7:0] pix_hi_q, pix_hi_d;
    logic       adv_q, adv_d;
    logic       pix_valid_q, pix_valid_d;
    rgb565_t    pix_data_q, pix_data_d;

    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        pstart_d    = pstart_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        ys_d        = ys_q;
        ye_d        = ye_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        pix_hi_d    = pix_hi_q;
        adv_d       = 1'b0;
        pix_valid_d = 1'b0;
        pix_data_d  = pix_data_q;

        // cursor moves one cycle after the pixel so pix_x/pix_y show where it landed
        if (adv_q) begin
            if (cur_x_q == xe_q) begin
                cur_x_d = xs_q;
                cur_y_d = (cur_y_q == ye_q) ? ys_q : cur_y_q + 8'd1;
            end else begin
                cur_x_d = cur_x_q + 8'd1;
            end
        end

        if (byte_done) begin
            if (!rs_s) begin
                pcnt_d = '0;
                case (new_byte)
                    CMD_CASET: state_d = DEC_CASET;
                    CMD_RASET: state_d = DEC_RASET;
                    CMD_RAMWR: begin
                        state_d = DEC_RAMWR_HI;
                        cur_x_d = xs_q;
                        cur_y_d = ys_q;
                    end
                    default:   state_d = DEC_IDLE;
                endcase
            end else begin
                case (state_q)
                    DEC_CASET, DEC_RASET: begin
                        pcnt_d = pcnt_q + 2'd1;
                        if (pcnt_q == 2'd1) pstart_d = new_byte;
                        if (pcnt_q == 2'd3) begin
                            if (state_q == DEC_CASET) begin
                                xs_d = pstart_q;
                                xe_d = new_byte;
                            end else begin
                                ys_d = pstart_q;
                                ye_d = new_byte;
                            end
                            state_d = DEC_IDLE;
                        end
                    end
                    DEC_RAMWR_HI: begin
                        pix_hi_d = new_byte;
                        state_d  = DEC_RAMWR_LO;
                    end
                    DEC_RAMWR_LO: begin
                        pix_valid_d = 1'b1;
                        pix_data_d  = rgb565_t'({pix_hi_q, new_byte});
                        adv_d       = 1'b1;
                        state_d     = DEC_RAMWR_HI;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= DEC_IDLE;
            pcnt_q      <= '0;
            pstart_q    <= '0;
            xs_q        <= '0;
            xe_q        <= XE_RST;
            ys_q        <= '0;
            ye_q        <= YE_RST;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            pix_hi_q    <= '0;
            adv_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else if (clr) begin
            state_q     <= DEC_IDLE;
            pcnt_q      <= '0;
            pstart_q    <= '0;
            xs_q        <= '0;
            xe_q        <= XE_RST;
            ys_q        <= '0;
            ye_q        <= YE_RST;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            pix_hi_q    <= '0;
            adv_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            pstart_q    <= pstart_d;
            xs_q        <= xs_d;
            xe_q        <= xe_d;
            ys_q        <= ys_d;
            ye_q        <= ye_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            pix_hi_q    <= pix_hi_d;
            adv_q       <= adv_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign pix_x     = cur_x_q;
    assign pix_y     = cur_y_q;
`else
    assign pix_valid = 1'b0;
    assign pix_data  = '0;
    assign pix_x     = '0;
    assign pix_y     = '0;
`endif

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed bench for lcd_spi_rx: drives the serial pins bit by bit and checks the byte and pixel streams.
// Pixel expectations switch with LCD_SPI_RX_PIXEL_DECODE_EN.
module tb_lcd_spi_rx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b1, scl = 1'b0, sda = 1'b0, rs = 1'b0, lcd_rst = 1'b1;
    logic        byte_valid, byte_is_data, frame_err, pix_valid;
    logic [7:0]  byte_data, pix_x, pix_y;
    logic [15:0] pix_data;

    lcd_spi_rx #(.WIDTH(128), .HEIGHT(160), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .scl(scl), .sda(sda), .rs(rs),
        .lcd_rst(lcd_rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_is_data(byte_is_data), .frame_err(frame_err), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_rise = 0;

    logic [8:0]  bq[$];
    int          lq[$];
    logic [15:0] pdq[$];
    logic [7:0]  pxq[$], pyq[$];
    logic        psq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid) begin
            bq.push_back({byte_is_data, byte_data});
            lq.push_back(cyc - last_rise);
        end
        if (pix_valid) begin
            pdq.push_back(pix_data);
            pxq.push_back(pix_x);
            pyq.push_back(pix_y);
            psq.push_back(byte_valid);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        bq.delete(); lq.delete(); pdq.delete(); pxq.delete(); pyq.delete(); psq.delete();
    endtask

    task automatic send_bit(input logic b, input logic r);
        sda = b;
        rs  = r;
        repeat (2) @(negedge clk);
        scl = 1'b1;
        last_rise = cyc;
        repeat (5) @(negedge clk);
        scl = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic r);
        for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (2) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    logic [7:0]  ex_x [5] = '{8'd5, 8'd6, 8'd5, 8'd6, 8'd5};
    logic [7:0]  ex_y [5] = '{8'd10, 8'd10, 8'd11, 8'd11, 8'd10};
    logic [15:0] pv;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_data", byte_data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_xy", {pix_x, pix_y, pix_data}, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // single RAMWR pixel
        clear_q();
        cs_low();
        send_byte(8'h2C, 1'b0);
        send_byte(8'hF8, 1'b1);
        send_byte(8'h00, 1'b1);
        cs_high();
        chk("t1_nbytes", bq.size(), 3);
        if (bq.size() == 3) begin
            chk("t1_b0", bq[0], {1'b0, 8'h2C});
            chk("t1_b1", bq[1], {1'b1, 8'hF8});
            chk("t1_b2", bq[2], {1'b1, 8'h00});
            chk("t1_latency", lq[0], 3);
        end
`ifdef LCD_SPI_RX_PIXEL_DECODE_EN
        chk("t1_npix", pdq.size(), 1);
        if (pdq.size() == 1) begin
            chk("t1_pix_data", pdq[0], 16'hF800);
            chk("t1_pix_xy", {pxq[0], pyq[0]}, 16'h0000);
            chk("t1_pix_with_byte", psq[0], 1);
        end
`else
        chk("t1_npix", pdq.size(), 0);
`endif

        // window set, five pixels with wrap in both directions
        clear_q();
        cs_low();
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h06, 1'b1);
        send_byte(8'h2B, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h0B, 1'b1);
        send_byte(8'h2C, 1'b0);
        for (int i = 0; i < 5; i++) begin
            pv = 16'h1234 + 16'(i * 16'h0101);
            send_byte(pv[15:8], 1'b1);
            send_byte(pv[7:0], 1'b1);
        end
        cs_high();
        chk("t2_nbytes", bq.size(), 21);
`ifdef LCD_SPI_RX_PIXEL_DECODE_EN
        chk("t2_npix", pdq.size(), 5);
        if (pdq.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("t2_pix%0d_xy", i), {pxq[i], pyq[i]}, {ex_x[i], ex_y[i]});
                chk($sformatf("t2_pix%0d_data", i), pdq[i], 16'h1234 + 16'(i * 16'h0101));
            end
        end
`else
        chk("t2_npix", pdq.size(), 0);
`endif
        chk("t2_frame_err", frame_err, 0);

        // truncated byte then a full one
        clear_q();
        cs_low();
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        cs_high();
        chk("t3_frame_err_set", frame_err, 1);
        cs_low();
        send_byte(8'hA5, 1'b0);
        cs_high();
        chk("t3_nbytes", bq.size(), 1);
        if (bq.size() == 1) chk("t3_byte", bq[0], {1'b0, 8'hA5});
        chk("t3_frame_err_sticky", frame_err, 1);

        // a command aborts a half pixel; data in IDLE is ignored
        clear_q();
        cs_low();
        send_byte(8'h2C, 1'b0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        cs_high();
        chk("t4_nbytes", bq.size(), 5);
        chk("t4_npix", pdq.size(), 0);

        // lcd_rst mid-RAMWR with a narrowed window
        clear_q();
        cs_low();
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h07, 1'b1);
        send_byte(8'h2C, 1'b0);
        send_byte(8'hAA, 1'b1);
`ifdef LCD_SPI_RX_PIXEL_DECODE_EN
        chk("t5_cursor_before", {pix_x, pix_y}, {8'd3, 8'd10});
`endif
        lcd_rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_byte_data_clr", byte_data, 0);
        chk("t5_byte_is_data_clr", byte_is_data, 0);
        chk("t5_frame_err_clr", frame_err, 0);
        chk("t5_pix_clr", {pix_x, pix_y, pix_data}, 0);
        lcd_rst = 1'b1;
        repeat (5) @(negedge clk);
        clear_q();
        send_byte(8'h2C, 1'b0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        cs_high();
        chk("t5_nbytes", bq.size(), 3);
`ifdef LCD_SPI_RX_PIXEL_DECODE_EN
        chk("t5_npix", pdq.size(), 1);
        if (pdq.size() == 1) begin
            chk("t5_pix_xy", {pxq[0], pyq[0]}, 16'h0000);
            chk("t5_pix_data", pdq[0], 16'h1234);
        end
`else
        chk("t5_npix", pdq.size(), 0);
`endif

        // asynchronous reset mid-byte
        cs_low();
        send_byte(8'h5A, 1'b1);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        chk("t6_byte_before", byte_data, 8'h5A);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_byte_data", byte_data, 0);
        chk("t6_async_is_data", byte_is_data, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        clear_q();
        send_byte(8'hC3, 1'b1);
        cs_high();
        chk("t6_nbytes", bq.size(), 1);
        if (bq.size() == 1) chk("t6_byte", bq[0], {1'b1, 8'hC3});
        chk("t6_frame_err", frame_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_spi_rx.md
# lcd_spi_rx

Receive-side model of the 4-wire serial LCD interface (cs, scl, sda, rs, lcd_rst) that the console chip drives. Oversamples the serial pins in the system clock domain, reassembles MSB-first bytes tagged command/data, and optionally decodes CASET/RASET/RAMWR into addressed RGB565 pixel writes. Used as an on-FPGA loopback target and as the display model in system benches.

## Interface
- WIDTH, 128: panel columns; must be ≤ 256.
- HEIGHT, 160: panel rows; must be ≤ 256.
- SYNC_STAGES, 2: synchronizer depth on cs/scl/sda/rs/lcd_rst; must be ≥ 2.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cs  in  1  chip select, active low, asynchronous to clk.
- scl  in  1  serial clock; sda sampled on its rising edge.
- sda  in  1  serial data, MSB first.
- rs  in  1  0 = command byte, 1 = data byte; sampled with bit 0.
- lcd_rst  in  1  panel reset, active low; synchronized, acts as a synchronous clear.
- byte_valid  out  1  one-cycle pulse per received byte.
- byte_data  out  8  received byte; held until next byte_valid.
- byte_is_data  out  1  rs value for byte_data.
- frame_err  out  1  sticky: cs deasserted with 1–7 bits received.
- pix_valid  out  1  one-cycle pulse per completed pixel.
- pix_data  out  16  RGB565, first byte in [15:8].
- pix_x  out  8  column of pix_data.
- pix_y  out  8  row of pix_data.

## Operation
- Reset (reset_n low, or synchronized lcd_rst low): all outputs 0; bit counter 0; decoder IDLE; window xs=0, xe=WIDTH-1, ys=0, ye=HEIGHT-1; cursor (0,0).
- Sampling: rising edge of synchronized scl while synchronized cs low shifts in sda; edges while cs high ignored.
- On 8th bit: byte_data, byte_is_data (rs at that edge) load, byte_valid pulses, bit counter returns to 0.
- cs rising with bit counter 1–7: partial byte discarded, frame_err set (cleared only by reset). cs rising does not change decoder state.
- Decoder states: IDLE, CASET (4 data bytes: XS hi, XS lo, XE hi, XE lo), RASET (same, rows), RAMWR_HI, RAMWR_LO.
- Any command byte: 0x2A → CASET, 0x2B → RASET, 0x2C → RAMWR_HI with cursor = (xs, ys), all others → IDLE. A command aborts any in-progress state; half-received pixel or partial window parameters discarded.
- Window parameters: only low bytes used; high bytes ignored. Window registers update after the 4th data byte. Values are not range-checked; start > end behaves as wrap at end (cursor compares equality only).
- Data bytes in IDLE are ignored.
- RAMWR_HI stores byte as pix_data[15:8]; RAMWR_LO completes pixel, pulses pix_valid with current cursor, then advances: if x == xe then x = xs, y = (y == ye) ? ys : y+1; else x+1. Return to RAMWR_HI.

## Timing
- Pin-to-internal latency SYNC_STAGES cycles, plus 1 cycle edge detect.
- byte_valid asserts SYNC_STAGES+1 clk cycles after the 8th scl rising edge at the pin.
- pix_valid asserts in the same cycle as the byte_valid of the RAMWR_LO byte; pix_x/pix_y show the pre-increment cursor that cycle, advance on the next.
- Input requirement: scl high and low each ≥ SYNC_STAGES+1 clk periods; sda and rs stable from 1 clk before to SYNC_STAGES+1 clk after each scl rising edge; cs low ≥ SYNC_STAGES+1 clk before first scl rise.
- Outputs are registered; no combinational paths from pins.

## Configuration
- LCD_SPI_RX_PIXEL_DECODE_EN defined: decoder, window/cursor registers and pix_* outputs as above.
- Undefined: decoder removed; pix_valid, pix_data, pix_x, pix_y tied to 0; byte stream and frame_err unchanged.

## Structure
- Shared package lcd_pkg: command codes CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C; decoder state enum; RGB565 pixel typedef.
- Sub-module lcd_sync_bit (parameterized SYNC_STAGES flop chain, reset value 1 for cs/scl/lcd_rst, 0 for sda/rs), instantiated per pin.

## Test plan
- Send command 0x2C then data 0xF8,0x00 → byte_valid ×3 with (0x2C,0),(0xF8,1),(0x00,1); pix_valid once, pix_data=16'hF800, (x,y)=(0,0).
- CASET 00,05,00,06; RASET 00,0A,00,0B; RAMWR + 5 pixels → pix (x,y) = (5,10),(6,10),(5,11),(6,11),(5,10).
- Raise cs after 3 bits, then send full byte 0xA5 → frame_err=1, one byte_valid with 0xA5.
- RAMWR, one data byte 0x12, then command 0x00, then data 0x34,0x56 → no pix_valid.
- Pulse lcd_rst low mid-RAMWR → all outputs 0, window reset; next RAMWR pixel at (0,0).
- Assert reset_n low asynchronously between clk edges mid-byte → outputs 0 immediately; next full byte received correctly.
